// File: rtl/mcse_lifecycle_manager.sv
// Lifecycle state manager: authenticated, forward-only lifecycle transitions with failure lockout.
// Latency: illegal request -> lc_done next cycle; auth sampled -> lc_done 2 cycles later; timeout -> lc_done on expiry edge.
// Backpressure: none; requests outside IDLE are dropped, a single transaction is in flight at a time.
module mcse_lifecycle_manager #(
    parameter int  ID_WIDTH     = 256,
    parameter int  NUM_STATES   = 5,
    parameter int  MAX_FAIL     = 3,
    parameter int  AUTH_TIMEOUT = 64,
    parameter int  LOCK_CYCLES  = 1024,
    localparam int SW           = $clog2(NUM_STATES),
    localparam int FW           = $clog2(MAX_FAIL + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lc_transition_request,
    input  logic [SW-1:0]       lc_target_state,
    input  logic [ID_WIDTH-1:0] lc_authentication_id,
    input  logic                lc_authentication_valid,
    input  logic [ID_WIDTH-1:0] lc_golden_id,
    output logic [SW-1:0]       lc_state,
    output logic                lc_done,
    output logic                lc_success,
    output logic                lc_locked,
    output logic [FW-1:0]       lc_fail_count
);

    localparam int TW = $clog2(AUTH_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [TW-1:0] AUTH_LAST = TW'(AUTH_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [SW-1:0] TERM_ST   = SW'(NUM_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_AUTH = 2'd1,
        S_CHECK     = 2'd2,
        S_LOCKOUT   = 2'd3
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [SW-1:0]       lc_state_q, lc_state_d;
    logic [SW-1:0]       target_q, target_d;
    logic [ID_WIDTH-1:0] auth_id_q, auth_id_d;
    logic                match_q, match_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [TW-1:0]       auth_tmr_q, auth_tmr_d;
    logic [LW-1:0]       lock_tmr_q, lock_tmr_d;
    logic                lc_done_q, lc_done_d;
    logic                lc_success_q, lc_success_d;
    logic                lc_locked_q, lc_locked_d;
    logic [FW-1:0]       fail_q, fail_d;

    logic                at_terminal;
    logic                target_legal;
    logic [SW:0]         next_up;
    logic                fail_evt;
    logic [FW-1:0]       fail_inc;

    // Legality of the presented target: one step forward, or a jump straight to the terminal (scrap) state.
    always_comb begin
        next_up      = {1'b0, lc_state_q} + (SW + 1)'(1);
        at_terminal  = (lc_state_q == TERM_ST);
        target_legal = !at_terminal &&
                       (({1'b0, lc_target_state} == next_up) || (lc_target_state == TERM_ST));
        fail_inc     = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);
    end

    // Transaction sequencing; the wide credential compare is registered in a first CHECK cycle and acted on in the second.
    always_comb begin
        fsm_d        = fsm_q;
        lc_state_d   = lc_state_q;
        target_d     = target_q;
        auth_id_d    = auth_id_q;
        match_d      = match_q;
        cmp_vld_d    = cmp_vld_q;
        auth_tmr_d   = auth_tmr_q;
        lock_tmr_d   = lock_tmr_q;
        lc_done_d    = 1'b0;
        lc_success_d = 1'b0;
        lc_locked_d  = lc_locked_q;
        fail_d       = fail_q;
        fail_evt     = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                // A credential strobe here has no transaction to belong to and is dropped.
                if (lc_transition_request) begin
                    if (target_legal) begin
                        target_d   = lc_target_state;
                        auth_tmr_d = '0;
                        fsm_d      = S_WAIT_AUTH;
                    end else begin
                        lc_done_d = 1'b1;
                    end
                end
            end
            S_WAIT_AUTH: begin
                if (lc_authentication_valid) begin
                    auth_id_d = lc_authentication_id;
                    cmp_vld_d = 1'b0;
                    fsm_d     = S_CHECK;
                end else if (auth_tmr_q == AUTH_LAST) begin
                    fail_evt = 1'b1;
                end else begin
                    auth_tmr_d = auth_tmr_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (!cmp_vld_q) begin
                    match_d   = (auth_id_q == lc_golden_id);
                    cmp_vld_d = 1'b1;
                end else if (match_q) begin
                    lc_state_d   = target_q;
                    lc_done_d    = 1'b1;
                    lc_success_d = 1'b1;
                    fail_d       = '0;
                    cmp_vld_d    = 1'b0;
                    fsm_d        = S_IDLE;
                end else begin
                    cmp_vld_d = 1'b0;
                    fail_evt  = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (lock_tmr_q == LOCK_LAST) begin
                    fail_d      = '0;
                    lc_locked_d = 1'b0;
                    fsm_d       = S_IDLE;
                end else begin
                    lock_tmr_d = lock_tmr_q + LW'(1);
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // Mismatch and timeout share one failure path: count, report, and lock out on the last allowed failure.
        if (fail_evt) begin
            lc_done_d = 1'b1;
            fail_d    = fail_inc;
            if (fail_inc == FAIL_MAX) begin
                lc_locked_d = 1'b1;
                lock_tmr_d  = '0;
                fsm_d       = S_LOCKOUT;
            end else begin
                fsm_d = S_IDLE;
            end
        end
    end

    // State and output registers; reset aborts any transaction without a completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            lc_state_q   <= '0;
            target_q     <= '0;
            auth_id_q    <= '0;
            match_q      <= 1'b0;
            cmp_vld_q    <= 1'b0;
            auth_tmr_q   <= '0;
            lock_tmr_q   <= '0;
            lc_done_q    <= 1'b0;
            lc_success_q <= 1'b0;
            lc_locked_q  <= 1'b0;
            fail_q       <= '0;
        end else begin
            fsm_q        <= fsm_d;
            lc_state_q   <= lc_state_d;
            target_q     <= target_d;
            auth_id_q    <= auth_id_d;
            match_q      <= match_d;
            cmp_vld_q    <= cmp_vld_d;
            auth_tmr_q   <= auth_tmr_d;
            lock_tmr_q   <= lock_tmr_d;
            lc_done_q    <= lc_done_d;
            lc_success_q <= lc_success_d;
            lc_locked_q  <= lc_locked_d;
            fail_q       <= fail_d;
        end
    end

    assign lc_state      = lc_state_q;
    assign lc_done       = lc_done_q;
    assign lc_success    = lc_success_q;
    assign lc_locked     = lc_locked_q;
    assign lc_fail_count = fail_q;

endmodule

// File: tb/tb_mcse_lifecycle_manager.sv
// Bench for the lifecycle manager: directed scenarios then randomized transactions against a transaction-level model.
// Latency: expectations are placed at fixed cycle offsets from request / credential / timeout.
// Backpressure: n/a.
module tb_mcse_lifecycle_manager;

    localparam int IDW      = 256;
    localparam int NST      = 5;
    localparam int MAXF     = 3;
    localparam int TMO      = 64;
    localparam int LOCKC    = 1024;
    localparam int SW       = $clog2(NST);
    localparam int FW       = $clog2(MAXF + 1);

    logic           clk;
    logic           rst_n;
    logic           lc_transition_request;
    logic [SW-1:0]  lc_target_state;
    logic [IDW-1:0] lc_authentication_id;
    logic           lc_authentication_valid;
    logic [IDW-1:0] lc_golden_id;
    logic [SW-1:0]  lc_state;
    logic           lc_done;
    logic           lc_success;
    logic           lc_locked;
    logic [FW-1:0]  lc_fail_count;

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model: current lifecycle state and consecutive-failure count.
    int m_state = 0;
    int m_fail  = 0;

    mcse_lifecycle_manager #(
        .ID_WIDTH    (IDW),
        .NUM_STATES  (NST),
        .MAX_FAIL    (MAXF),
        .AUTH_TIMEOUT(TMO),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .lc_transition_request  (lc_transition_request),
        .lc_target_state        (lc_target_state),
        .lc_authentication_id   (lc_authentication_id),
        .lc_authentication_valid(lc_authentication_valid),
        .lc_golden_id           (lc_golden_id),
        .lc_state               (lc_state),
        .lc_done                (lc_done),
        .lc_success             (lc_success),
        .lc_locked              (lc_locked),
        .lc_fail_count          (lc_fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IDW-1:0] rand_id();
        logic [IDW-1:0] v;
        for (int i = 0; i < IDW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic apply_reset();
        lc_transition_request   = 1'b0;
        lc_authentication_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_eq("rst_state",  32'(lc_state), 0);
        chk_eq("rst_done",   32'(lc_done), 0);
        chk_eq("rst_succ",   32'(lc_success), 0);
        chk_eq("rst_locked", 32'(lc_locked), 0);
        chk_eq("rst_fail",   32'(lc_fail_count), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_state = 0;
        m_fail  = 0;
    endtask

    // mode: 0 correct credential, 1 wrong credential, 2 no credential (timeout).
    task automatic do_txn(input int tgt, input int mode, input int dly, input bit coinc);
        bit             legal;
        int             bad;
        bit             exp_succ;
        logic [IDW-1:0] wrong;
        lc_golden_id = rand_id();
        wrong = lc_golden_id;
        wrong[$urandom_range(IDW - 1, 0)] ^= 1'b1;
        legal = (m_state != NST - 1) && ((tgt == m_state + 1) || (tgt == NST - 1));

        lc_transition_request = 1'b1;
        lc_target_state       = SW'(tgt);
        if (coinc) begin
            lc_authentication_valid = 1'b1;
            lc_authentication_id    = lc_golden_id;
        end
        tick();
        lc_transition_request   = 1'b0;
        lc_authentication_valid = 1'b0;

        if (!legal) begin
            chk_eq("illegal_done",  32'(lc_done), 1);
            chk_eq("illegal_succ",  32'(lc_success), 0);
            chk_eq("illegal_state", 32'(lc_state), 32'(m_state));
            chk_eq("illegal_fail",  32'(lc_fail_count), 32'(m_fail));
            tick();
            chk_eq("illegal_done_pulse", 32'(lc_done), 0);
            return;
        end

        bad = lc_done ? 1 : 0;
        if (mode == 2) begin
            for (int i = 0; i < TMO - 1; i++) begin
                lc_transition_request = ($urandom_range(3, 0) == 0);
                lc_target_state       = SW'($urandom_range(7, 0));
                tick();
                if (lc_done) bad++;
            end
            lc_transition_request = 1'b0;
            tick();
        end else begin
            for (int i = 0; i < dly; i++) begin
                lc_transition_request = ($urandom_range(3, 0) == 0);
                lc_target_state       = SW'($urandom_range(7, 0));
                tick();
                if (lc_done) bad++;
            end
            lc_transition_request   = 1'b0;
            lc_authentication_valid = 1'b1;
            lc_authentication_id    = (mode == 0) ? lc_golden_id : wrong;
            tick();
            lc_authentication_valid = 1'b0;
            lc_authentication_id    = rand_id();
            if (lc_done) bad++;
            tick();
            if (lc_done) bad++;
            tick();
        end
        chk_eq("no_early_done", 32'(bad), 0);

        exp_succ = (mode == 0);
        if (exp_succ) begin
            m_state = tgt;
            m_fail  = 0;
        end else begin
            m_fail = m_fail + 1;
        end
        chk_eq("txn_done",   32'(lc_done), 1);
        chk_eq("txn_succ",   32'(lc_success), 32'(exp_succ));
        chk_eq("txn_state",  32'(lc_state), 32'(m_state));
        chk_eq("txn_fail",   32'(lc_fail_count), 32'(m_fail));
        chk_eq("txn_locked", 32'(lc_locked), 32'(m_fail == MAXF));

        if (m_fail == MAXF) begin
            bad = 0;
            for (int i = 0; i < LOCKC - 1; i++) begin
                lc_transition_request = ($urandom_range(3, 0) == 0);
                lc_target_state       = SW'($urandom_range(7, 0));
                tick();
                if (lc_done || !lc_locked) bad++;
            end
            lc_transition_request = 1'b0;
            chk_eq("lockout_quiet", 32'(bad), 0);
            tick();
            m_fail = 0;
            chk_eq("lockout_exit_locked", 32'(lc_locked), 0);
            chk_eq("lockout_exit_fail",   32'(lc_fail_count), 0);
            chk_eq("lockout_exit_done",   32'(lc_done), 0);
        end else begin
            tick();
            chk_eq("txn_done_pulse", 32'(lc_done), 0);
        end
    endtask

    task automatic reset_mid_op();
        int bad;
        apply_reset();
        lc_golden_id          = rand_id();
        lc_transition_request = 1'b1;
        lc_target_state       = SW'(1);
        tick();
        lc_transition_request = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk_eq("midrst_done",  32'(lc_done), 0);
        chk_eq("midrst_state", 32'(lc_state), 0);
        tick();
        rst_n = 1'b1;
        m_state = 0;
        m_fail  = 0;
        lc_authentication_valid = 1'b1;
        lc_authentication_id    = lc_golden_id;
        tick();
        lc_authentication_valid = 1'b0;
        bad = lc_done ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (lc_done) bad++;
        end
        chk_eq("late_auth_no_done", 32'(bad), 0);
        chk_eq("late_auth_state",   32'(lc_state), 0);
    endtask

    initial begin
        int tgt;
        int mode;
        int r;
        rst_n                   = 1'b0;
        lc_transition_request   = 1'b0;
        lc_target_state         = '0;
        lc_authentication_id    = '0;
        lc_authentication_valid = 1'b0;
        lc_golden_id            = '0;

        apply_reset();

        do_txn(1, 0, 3, 1'b0);   // legal step 0 -> 1
        do_txn(3, 0, 0, 1'b0);   // illegal jump from 1
        do_txn(0, 0, 0, 1'b0);   // backwards is illegal
        do_txn(2, 1, 2, 1'b1);   // wrong id, coincident strobe in IDLE ignored
        do_txn(2, 1, 0, 1'b0);
        do_txn(2, 1, 5, 1'b0);   // third failure -> lockout
        do_txn(2, 2, 0, 1'b0);   // timeout
        do_txn(2, 0, 40, 1'b0);  // success clears failures
        do_txn(4, 0, 1, 1'b0);   // scrap from state 2
        do_txn(4, 0, 0, 1'b0);   // terminal: everything rejected
        do_txn(0, 0, 0, 1'b0);
        reset_mid_op();

        for (int n = 0; n < 40; n++) begin
            if ((m_state == NST - 1 && $urandom_range(1, 0) == 0) || $urandom_range(11, 0) == 0)
                apply_reset();
            if (m_state < NST - 1 && $urandom_range(9, 0) < 6) tgt = m_state + 1;
            else tgt = $urandom_range(7, 0);
            r = $urandom_range(19, 0);
            mode = (r < 12) ? 0 : ((r < 17) ? 1 : 2);
            do_txn(tgt, mode, $urandom_range(40, 0), bit'($urandom_range(3, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mcse_lifecycle_manager.md
MCSE_LIFECYCLE_MANAGER -- requirements
Module: mcse_lifecycle_manager

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 256: width of the transition, authentication and golden identifiers.
REQ-002 SHALL have parameter NUM_STATES, default 5: number of lifecycle states, with SW = $clog2(NUM_STATES).
REQ-003 SHALL have parameter MAX_FAIL, default 3: consecutive failed authentications that trigger lockout.
REQ-004 SHALL have parameter AUTH_TIMEOUT, default 64: cycles to wait for authentication after a request.
REQ-005 SHALL have parameter LOCK_CYCLES, default 1024: lockout duration in cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port lc_transition_request, input, 1 bit: single-cycle request strobe.
REQ-009 SHALL have port lc_target_state, input, SW bits: the requested next state.
REQ-010 SHALL have port lc_authentication_id, input, ID_WIDTH bits: the credential.
REQ-011 SHALL have port lc_authentication_valid, input, 1 bit: credential strobe.
REQ-012 SHALL have port lc_golden_id, input, ID_WIDTH bits: the expected credential from secure memory, stable during a transaction.
REQ-013 SHALL have port lc_state, output, SW bits: the current lifecycle state.
REQ-014 SHALL have port lc_done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port lc_success, output, 1 bit: valid only while lc_done=1.
REQ-016 SHALL have port lc_locked, output, 1 bit: high while the FSM is in LOCKOUT.
REQ-017 SHALL have port lc_fail_count, output, $clog2(MAX_FAIL+1) bits: the consecutive-failure count.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_AUTH, CHECK and LOCKOUT.
REQ-019 SHALL define a target as legal iff lc_target_state==lc_state+1, or lc_target_state==NUM_STATES-1 while lc_state!=NUM_STATES-1.
REQ-020 SHALL, in IDLE, on lc_transition_request with a legal target: latch the target, clear the timer, and enter WAIT_AUTH.
REQ-021 SHALL, in IDLE, on lc_transition_request with an illegal target, or while in the terminal state: pulse lc_done=1 with lc_success=0 on the next cycle, stay in IDLE, and leave lc_fail_count unchanged.
REQ-022 SHALL ignore lc_authentication_valid while in IDLE, including when it coincides with a request.
REQ-023 SHALL, in WAIT_AUTH, when lc_authentication_valid=1: latch lc_authentication_id and enter CHECK.
REQ-024 SHALL, in WAIT_AUTH, treat AUTH_TIMEOUT cycles without lc_authentication_valid as a failure handled per REQ-026.
REQ-025 SHALL, in CHECK, on a full-width equality match against lc_golden_id: set lc_state to the latched target, pulse lc_done and lc_success, clear lc_fail_count, and return to IDLE.
REQ-026 SHALL, in CHECK on a mismatch, or on timeout: increment lc_fail_count and pulse lc_done with lc_success=0.
REQ-027 SHALL, after REQ-026, enter LOCKOUT when the incremented count equals MAX_FAIL, and otherwise return to IDLE.
REQ-028 SHALL pulse lc_done exactly 2 cycles after the edge that samples lc_authentication_valid.
REQ-029 SHALL pulse lc_done on the edge on which a timeout expires.
REQ-030 SHALL, in LOCKOUT, hold lc_locked=1 and silently ignore requests (no lc_done) for exactly LOCK_CYCLES cycles.
REQ-031 SHALL, at the end of LOCKOUT, clear lc_fail_count and lc_locked and enter IDLE.
REQ-032 SHALL ignore requests arriving in WAIT_AUTH or CHECK; the in-flight transaction continues unaffected.
REQ-033 SHALL never let lc_state decrease, and SHALL change lc_state only in CHECK on a match.
REQ-034 SHALL saturate all counters and never wrap; lc_fail_count never exceeds MAX_FAIL.
REQ-035 SHALL register all outputs.

Reset
REQ-036 SHALL, while rst_n=0 (asynchronously): set FSM=IDLE, lc_state=0, lc_done=0, lc_success=0, lc_locked=0, lc_fail_count=0, and clear all timers and latched data.
REQ-037 SHALL, on reset asserted mid-transaction or in LOCKOUT: abort the transaction, produce no lc_done pulse, and resume in IDLE from state 0.

Verification
REQ-038 SHALL cover a legal transition: at state 0, request target=1, then after 3 cycles auth with id==golden -> lc_done=lc_success=1 two cycles later, lc_state=1.
REQ-039 SHALL cover an illegal target: at state 1, request target=3 (NUM_STATES=5) -> next cycle lc_done=1, lc_success=0, lc_state=1, lc_fail_count=0.
REQ-040 SHALL cover lockout: three requests each answered with a wrong id -> lc_fail_count goes 1, 2, then lc_locked=1; requests during the next 1024 cycles produce no lc_done; then lc_locked=0 and lc_fail_count=0.
REQ-041 SHALL cover timeout: request with no auth for 64 cycles -> lc_done=1, lc_success=0, lc_fail_count=1.
REQ-042 SHALL cover scrap from any state: at state 2, request target=4 with a correct id -> lc_state=4; any later request -> lc_done with lc_success=0.
REQ-043 SHALL cover reset mid-operation: rst_n low during WAIT_AUTH, then a late auth after release -> no lc_done, lc_state=0.
